// File: rtl/memoredf_pkg.sv
// Shared types and constants for the MemorEDF memory-request path.
package memoredf_pkg;

  // Issuer transaction phases: idle, request on the bus, waiting for response.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } issuer_state_t;

  localparam int unsigned DEFAULT_PACKET_SIZE      = 64;
  localparam int unsigned DEFAULT_NUMBER_OF_QUEUES = 4;

  // Width of a queue tag; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEFAULT_ID_WIDTH = id_width(DEFAULT_NUMBER_OF_QUEUES);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count up on increment, holding at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (increment && !(&count_q)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/transaction_issuer.sv
// Issues the scheduler-selected head packet on a single-outstanding valid/ready port
// and reports completion via the level signal consumed.
// Optional WAIT watchdog: define TRANSACTION_ISSUER_WATCHDOG_EN.
module transaction_issuer
  import memoredf_pkg::*;
#(
  parameter int unsigned NUMBER_OF_QUEUES = 4,
  parameter int unsigned PACKET_SIZE      = DEFAULT_PACKET_SIZE,
  parameter int unsigned REGISTER_SIZE    = 32,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             enable,
  input  logic [id_width(NUMBER_OF_QUEUES)-1:0]            id,
  input  logic [NUMBER_OF_QUEUES-1:0][PACKET_SIZE-1:0]     headPackets,
  output logic                                             m_valid,
  input  logic                                             m_ready,
  output logic [PACKET_SIZE-1:0]                           m_packet,
  output logic [id_width(NUMBER_OF_QUEUES)-1:0]            m_id,
  input  logic                                             resp_valid,
  output logic                                             consumed,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   completed,
  output logic                                             timeout
);

  localparam int unsigned IdWidth = id_width(NUMBER_OF_QUEUES);

  issuer_state_t          state_q, state_d;
  logic [PACKET_SIZE-1:0] packet_q;
  logic [IdWidth-1:0]     id_q;
  logic                   consumed_q;
  logic                   timeout_q, timeout_d;
  logic                   latch;
  logic                   done;
  logic                   expire;

`ifdef TRANSACTION_ISSUER_WATCHDOG_EN
  localparam int unsigned    CntWidth = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

  logic [CntWidth-1:0] wait_cnt_q;

  // Count cycles spent in WAIT; any other state clears it so each WAIT starts at zero.
  always_ff @(posedge clock) begin
    if (reset || (state_q != StWait)) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign expire = (wait_cnt_q == CntLast);
`else
  assign expire = 1'b0;
`endif

  // Next-state decode; a response in the final watchdog cycle still completes normally.
  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    done      = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          latch   = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (m_ready) state_d = StWait;
      end
      StWait: begin
        if (resp_valid) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request latch and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      packet_q   <= '0;
      id_q       <= '0;
      consumed_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      consumed_q <= (state_d == StIdle);
      timeout_q  <= timeout_d;
      if (latch) begin
        packet_q <= headPackets[id];
        id_q     <= id;
      end
    end
  end

  assign m_valid  = (state_q == StIssue);
  assign m_packet = packet_q;
  assign m_id     = id_q;
  assign consumed = consumed_q;
  assign timeout  = timeout_q;

  for (genvar q = 0; q < NUMBER_OF_QUEUES; q++) begin : g_completed
    sat_counter #(
      .WIDTH(REGISTER_SIZE)
    ) u_count (
      .clock    (clock),
      .reset    (reset),
      .increment(done && (id_q == IdWidth'(q))),
      .count    (completed[q])
    );
  end

endmodule

// File: tb/tb_transaction_issuer.sv
// Scoreboard bench for transaction_issuer; watchdog expectations follow
// TRANSACTION_ISSUER_WATCHDOG_EN.
module tb_transaction_issuer;

  localparam int unsigned NQ = 4;
  localparam int unsigned PW = 64;
  localparam int unsigned RW = 3;
  localparam int unsigned TO = 8;
  localparam int unsigned SatMax = (1 << RW) - 1;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [1:0]             id;
  logic [NQ-1:0][PW-1:0]  head_packets;
  logic                   m_valid;
  logic                   m_ready;
  logic [PW-1:0]          m_packet;
  logic [1:0]             m_id;
  logic                   resp_valid;
  logic                   consumed;
  logic [NQ-1:0][RW-1:0]  completed;
  logic                   timeout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct packed {
    logic [1:0]    qid;
    logic [PW-1:0] pkt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned model[NQ];
  logic        consumed_prev = 1'b0;

  transaction_issuer #(
    .NUMBER_OF_QUEUES(NQ),
    .PACKET_SIZE     (PW),
    .REGISTER_SIZE   (RW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .id         (id),
    .headPackets(head_packets),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_packet   (m_packet),
    .m_id       (m_id),
    .resp_valid (resp_valid),
    .consumed   (consumed),
    .completed  (completed),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: pop on handshake, compare counters on every consumed rising edge.
  always @(negedge clock) begin
    if (!reset && m_valid && m_ready) begin
      exp_t e;
      check_eq("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sb_m_id", 64'(m_id), 64'(e.qid));
        check_eq("sb_m_packet", m_packet, e.pkt);
      end
    end
    if (consumed && !consumed_prev) begin
      for (int q = 0; q < NQ; q++) begin
        check_eq($sformatf("sb_completed%0d", q), 64'(completed[q]), 64'(model[q]));
      end
    end
    consumed_prev <= consumed;
  end

  task automatic model_complete(input logic [1:0] q);
    if (model[q] < SatMax) model[q]++;
  endtask

  task automatic start_txn(input logic [1:0] q, input logic [PW-1:0] pkt);
    exp_t e;
    head_packets[q] = pkt;
    id     = q;
    enable = 1'b1;
    e.qid  = q;
    e.pkt  = pkt;
    exp_q.push_back(e);
    tick();
    enable = 1'b0;
    check_eq("issue_m_valid", 64'(m_valid), 64'd1);
    check_eq("issue_consumed", 64'(consumed), 64'd0);
    check_eq("issue_m_packet", m_packet, pkt);
    check_eq("issue_m_id", 64'(m_id), 64'(q));
  endtask

  // Entered one cycle after the enable edge; stalls, then handshake, then response.
  task automatic finish_txn(input logic [1:0] q, input logic [PW-1:0] pkt,
                            input int ready_delay, input int resp_delay);
    for (int i = 0; i < ready_delay; i++) begin
      enable     = (i == 1);
      id         = q + 2'd1;
      head_packets[q + 2'd1] = ~pkt;
      resp_valid = (i == 2);
      tick();
      check_eq("bp_m_valid", 64'(m_valid), 64'd1);
      check_eq("bp_m_packet", m_packet, pkt);
      check_eq("bp_m_id", 64'(m_id), 64'(q));
    end
    enable     = 1'b0;
    resp_valid = 1'b0;
    m_ready    = 1'b1;
    tick();
    m_ready = 1'b0;
    check_eq("hs_m_valid_low", 64'(m_valid), 64'd0);
    check_eq("wait_consumed", 64'(consumed), 64'd0);
    for (int i = 0; i < resp_delay; i++) begin
      enable = (i == 0);
      id     = q + 2'd1;
      tick();
      check_eq("wait_consumed_hold", 64'(consumed), 64'd0);
      check_eq("wait_m_id", 64'(m_id), 64'(q));
    end
    enable     = 1'b0;
    resp_valid = 1'b1;
    model_complete(q);
    tick();
    resp_valid = 1'b0;
    check_eq("done_consumed", 64'(consumed), 64'd1);
    check_eq("done_m_valid", 64'(m_valid), 64'd0);
    check_eq("idle_m_packet_kept", m_packet, pkt);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    id           = '0;
    m_ready      = 1'b0;
    resp_valid   = 1'b0;
    head_packets = '0;
    for (int q = 0; q < NQ; q++) model[q] = 0;
    tick();
    tick();
    check_eq("rst_consumed", 64'(consumed), 64'd0);
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_timeout", 64'(timeout), 64'd0);
    check_eq("rst_m_packet", m_packet, 64'd0);
    check_eq("rst_m_id", 64'(m_id), 64'd0);
    check_eq("rst_completed", 64'(completed), 64'd0);
    reset = 1'b0;
    tick();
    check_eq("boot_consumed", 64'(consumed), 64'd1);
    check_eq("boot_m_valid", 64'(m_valid), 64'd0);

    // Minimum round trip on queue 2.
    start_txn(2'd2, 64'hDEAD_BEEF);
    finish_txn(2'd2, 64'hDEAD_BEEF, 0, 0);
    check_eq("basic_completed2", 64'(completed[2]), 64'd1);

    // Backpressure with stray enable/response pulses.
    start_txn(2'd0, 64'h0123_4567_89AB_CDEF);
    finish_txn(2'd0, 64'h0123_4567_89AB_CDEF, 5, 2);
    check_eq("bp_completed0", 64'(completed[0]), 64'd1);

    start_txn(2'd3, 64'hFEDC_0000_1111_2222);
    finish_txn(2'd3, 64'hFEDC_0000_1111_2222, 1, 3);

    // Saturation on queue 1.
    for (int i = 0; i < 9; i++) begin
      start_txn(2'd1, 64'h1000 + 64'(i));
      finish_txn(2'd1, 64'h1000 + 64'(i), 0, 0);
    end
    check_eq("sat_completed1", 64'(completed[1]), 64'd7);

    // No response after the handshake.
    start_txn(2'd0, 64'hA5A5_A5A5);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check_eq("wd_pre_timeout", 64'(timeout), 64'd0);
      check_eq("wd_pre_consumed", 64'(consumed), 64'd0);
    end
    tick();
`ifdef TRANSACTION_ISSUER_WATCHDOG_EN
    check_eq("wd_timeout", 64'(timeout), 64'd1);
    check_eq("wd_consumed", 64'(consumed), 64'd1);
    tick();
    check_eq("wd_timeout_pulse", 64'(timeout), 64'd0);
    check_eq("wd_completed0", 64'(completed[0]), 64'(model[0]));
`else
    check_eq("nowd_timeout", 64'(timeout), 64'd0);
    check_eq("nowd_consumed", 64'(consumed), 64'd0);
    check_eq("nowd_m_valid", 64'(m_valid), 64'd0);
    repeat (4) tick();
    check_eq("nowd_still_wait", 64'(consumed), 64'd0);
    resp_valid = 1'b1;
    model_complete(2'd0);
    tick();
    resp_valid = 1'b0;
    check_eq("nowd_done_consumed", 64'(consumed), 64'd1);
    check_eq("nowd_completed0", 64'(completed[0]), 64'd2);
`endif

    // Reset while waiting on queue 3, then a late response.
    start_txn(2'd3, 64'h3333_3333);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    reset = 1'b1;
    for (int q = 0; q < NQ; q++) model[q] = 0;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_consumed", 64'(consumed), 64'd0);
    check_eq("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("mid_rst_m_packet", m_packet, 64'd0);
    check_eq("mid_rst_completed", 64'(completed), 64'd0);
    tick();
    tick();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    check_eq("late_resp_completed3", 64'(completed[3]), 64'd0);
    check_eq("late_resp_consumed", 64'(consumed), 64'd1);
    check_eq("late_resp_m_valid", 64'(m_valid), 64'd0);

    tick();
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
